// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI ADC command master: frame geometry, FSM states
// and the layout of one buffered command.
package spi_cmd_pkg;

   localparam int FRAME_BITS = 20;
   localparam int ENTRY_BITS = 21;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   typedef struct packed {
      logic        sel;
      logic [3:0]  addr;
      logic [15:0] data;
   } cmd_entry_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Show-ahead synchronous command FIFO; a push while full is accepted only
// when a pop frees the slot in the same cycle.
module spi_cmd_fifo
   import spi_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic       pop,
   input  cmd_entry_t din,
   output cmd_entry_t dout,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0] wr_q, wr_d;
   logic [AW:0] rd_q, rd_d;
   cmd_entry_t  mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + PTR_ONE;
      if (do_pop)  rd_d = rd_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/spi_adc_cmd_master.sv
// Buffers edge-triggered ADC configuration commands and serialises each as a
// 20-bit SPI mode-0 frame (MSB first) to one of two chip selects.
module spi_adc_cmd_master
   import spi_cmd_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   input  logic        cmd_sel,
   input  logic [3:0]  cmd_addr,
   input  logic [15:0] cmd_data,
   input  logic        ovf_clr,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow,
   output logic        done,
   output logic        sclk,
   output logic        mosi,
   output logic [1:0]  cs_n
);

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

   logic        cmd_valid_q;
   logic        push;
   logic        pop;
   logic        fifo_empty;
   cmd_entry_t  fifo_din;
   cmd_entry_t  fifo_dout;

   logic        ovf_q, ovf_d;
   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [4:0]  bit_q, bit_d;
   logic        ph_q, ph_d;
   logic        sel_q, sel_d;
   logic [FRAME_BITS-2:0] shift_q, shift_d;
   logic [1:0]  cs_n_q, cs_n_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        done_q, done_d;
   logic        div_end;

   assign push          = cmd_valid & ~cmd_valid_q;
   assign fifo_din.sel  = cmd_sel;
   assign fifo_din.addr = cmd_addr;
   assign fifo_din.data = cmd_data;

   spi_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A clear loses to a drop in the same cycle so no drop goes unreported.
   always_comb begin
      ovf_d = ovf_q;
      if (push && fifo_full && !pop) ovf_d = 1'b1;
      else if (ovf_clr)              ovf_d = 1'b0;
   end

   assign div_end = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      sel_d   = sel_q;
      shift_d = shift_q;
      cs_n_d  = cs_n_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sel_d   = fifo_dout.sel;
               shift_d = {fifo_dout.addr[2:0], fifo_dout.data};
               mosi_d  = fifo_dout.addr[3];
               cs_n_d  = fifo_dout.sel ? 2'b01 : 2'b10;
               sclk_d  = 1'b0;
               div_d   = '0;
               bit_d   = '0;
               ph_d    = 1'b0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (div_end) begin
               div_d   = '0;
               state_d = SHIFT;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         SHIFT: begin
            if (!div_end) begin
               div_d = div_q + 8'd1;
            end else begin
               div_d = '0;
               if (!ph_q) begin
                  ph_d   = 1'b1;
                  sclk_d = 1'b1;
               end else begin
                  // Falling edge: present the next bit, or finish after bit 19.
                  ph_d   = 1'b0;
                  sclk_d = 1'b0;
                  if (bit_q == BIT_LAST) begin
                     state_d = HOLD;
                  end else begin
                     mosi_d  = shift_q[FRAME_BITS-2];
                     shift_d = {shift_q[FRAME_BITS-3:0], 1'b0};
                     bit_d   = bit_q + 5'd1;
                  end
               end
            end
         end
         HOLD: begin
            if (div_end) begin
               div_d   = '0;
               cs_n_d  = 2'b11;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
               state_d = GAP;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         GAP: begin
            if (div_end) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         state_q     <= IDLE;
         div_q       <= '0;
         bit_q       <= '0;
         ph_q        <= 1'b0;
         sel_q       <= 1'b0;
         cs_n_q      <= 2'b11;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cmd_valid_q <= cmd_valid;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         ph_q        <= ph_d;
         sel_q       <= sel_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   assign busy     = ~fifo_empty | (state_q != IDLE);
   assign overflow = ovf_q;
   assign done     = done_q;
   assign sclk     = sclk_q;
   assign mosi     = mosi_q;
   assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_adc_cmd_master.sv
// Scoreboard bench: stimulus queues expected frames, bus monitors decode SPI
// frames from each DUT and compare them in order.
`timescale 1ns/1ps
module tb_spi_adc_cmd_master;

   localparam int CD  = 4;
   localparam int CD2 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0, cmd_sel = 1'b0, ovf_clr = 1'b0;
   logic [3:0]  cmd_addr = '0;
   logic [15:0] cmd_data = '0;
   logic        busy, fifo_full, overflow, done, sclk, mosi;
   logic [1:0]  cs_n;

   logic        cmd_valid2 = 1'b0, cmd_sel2 = 1'b0, ovf_clr2 = 1'b0;
   logic [3:0]  cmd_addr2 = '0;
   logic [15:0] cmd_data2 = '0;
   logic        busy2, fifo_full2, overflow2, done2, sclk2, mosi2;
   logic [1:0]  cs_n2;

   spi_adc_cmd_master #(.CLK_DIV(CD), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data), .ovf_clr(ovf_clr),
      .busy(busy), .fifo_full(fifo_full), .overflow(overflow), .done(done),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n));

   spi_adc_cmd_master #(.CLK_DIV(CD2), .FIFO_DEPTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_sel(cmd_sel2),
      .cmd_addr(cmd_addr2), .cmd_data(cmd_data2), .ovf_clr(ovf_clr2),
      .busy(busy2), .fifo_full(fifo_full2), .overflow(overflow2), .done(done2),
      .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2));

   int n_chk = 0, n_fail = 0;
   int n_done = 0, n_done2 = 0, n_sent = 0, n_sent2 = 0;
   logic [20:0] exp_q[$];
   logic [20:0] exp2_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
      end
   endtask

   task automatic send(input logic s, input logic [3:0] a, input logic [15:0] d, input bit acc);
      @(posedge clk); #1;
      cmd_sel = s; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      if (acc) begin exp_q.push_back({s, a, d}); n_sent++; end
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_sel = ~s; cmd_addr = ~a; cmd_data = ~d;
   endtask

   task automatic send2(input logic s, input logic [3:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      cmd_sel2 = s; cmd_addr2 = a; cmd_data2 = d; cmd_valid2 = 1'b1;
      exp2_q.push_back({s, a, d}); n_sent2++;
      @(posedge clk); #1;
      cmd_valid2 = 1'b0; cmd_data2 = ~d;
   endtask

   task automatic wait_idle(input bit which, input int max);
      int n = 0;
      while (n < max) begin
         @(negedge clk);
         if (!(which ? busy2 : busy)) break;
         n++;
      end
      chk("idle_timeout", 32'(n < max), 32'd1);
   endtask

   // Bus monitor for dut
   logic [1:0]  m_pcs = 2'b11;
   logic        m_psclk = 1'b0, m_sel = 1'b0, m_seen = 1'b0;
   int          m_bits = 0, m_low = 0, m_high = 0;
   logic [19:0] m_sh = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         m_pcs = 2'b11; m_psclk = 1'b0; m_seen = 1'b0; m_bits = 0; m_low = 0; m_high = 0;
      end else begin
         if (done) begin
            n_done++;
            chk("done_at_cs_rise", 32'(m_pcs != 2'b11 && cs_n == 2'b11), 32'd1);
         end
         if (m_pcs == 2'b11 && cs_n != 2'b11) begin
            chk("cs_one_low", 32'(cs_n != 2'b00), 32'd1);
            if (m_seen) chk("gap_min", 32'(m_high >= CD), 32'd1);
            m_sel = (cs_n == 2'b01); m_bits = 0; m_low = 1; m_sh = '0;
         end else if (m_pcs != 2'b11 && cs_n != 2'b11) begin
            m_low++;
            if (cs_n != m_pcs) chk("cs_stable", 32'(cs_n), 32'(m_pcs));
         end else if (m_pcs != 2'b11 && cs_n == 2'b11) begin
            chk("frame_done", 32'(done), 32'd1);
            chk("frame_bits", m_bits, 20);
            chk("cs_low_len", m_low, 42 * CD);
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL frame_unexpected: got 0x%0h, want no frame", {m_sel, m_sh});
            end else begin
               chk("frame_data", 32'({m_sel, m_sh}), 32'(exp_q.pop_front()));
            end
            m_seen = 1'b1; m_high = 1;
         end else begin
            m_high++;
         end
         if (cs_n != 2'b11 && sclk && !m_psclk) begin
            m_sh = {m_sh[18:0], mosi}; m_bits++;
         end
         m_pcs = cs_n; m_psclk = sclk;
      end
   end

   // Bus monitor for dut2
   logic [1:0]  k_pcs = 2'b11;
   logic        k_psclk = 1'b0, k_sel = 1'b0, k_seen = 1'b0;
   int          k_bits = 0, k_low = 0, k_high = 0;
   logic [19:0] k_sh = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         k_pcs = 2'b11; k_psclk = 1'b0; k_seen = 1'b0; k_bits = 0; k_low = 0; k_high = 0;
      end else begin
         if (done2) begin
            n_done2++;
            chk("done2_at_cs_rise", 32'(k_pcs != 2'b11 && cs_n2 == 2'b11), 32'd1);
         end
         if (k_pcs == 2'b11 && cs_n2 != 2'b11) begin
            chk("cs2_one_low", 32'(cs_n2 != 2'b00), 32'd1);
            if (k_seen) chk("gap2_min", 32'(k_high >= CD2), 32'd1);
            k_sel = (cs_n2 == 2'b01); k_bits = 0; k_low = 1; k_sh = '0;
         end else if (k_pcs != 2'b11 && cs_n2 != 2'b11) begin
            k_low++;
            if (cs_n2 != k_pcs) chk("cs2_stable", 32'(cs_n2), 32'(k_pcs));
         end else if (k_pcs != 2'b11 && cs_n2 == 2'b11) begin
            chk("frame2_bits", k_bits, 20);
            chk("cs2_low_len", k_low, 42 * CD2);
            if (exp2_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL frame2_unexpected: got 0x%0h, want no frame", {k_sel, k_sh});
            end else begin
               chk("frame2_data", 32'({k_sel, k_sh}), 32'(exp2_q.pop_front()));
            end
            k_seen = 1'b1; k_high = 1;
         end else begin
            k_high++;
         end
         if (cs_n2 != 2'b11 && sclk2 && !k_psclk) begin
            k_sh = {k_sh[18:0], mosi2}; k_bits++;
         end
         k_pcs = cs_n2; k_psclk = sclk2;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int done_before;
      // Reset values
      #3 rst_n = 1'b0;
      #2;
      chk("rst_cs_n", 32'(cs_n), 32'h3);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf",  32'(overflow), 32'd0);
      chk("rst_full", 32'(fifo_full), 32'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // 1: single frame, frame 0x03A5C3 on cs_n[0], cs low one clk after pop
      send(1'b0, 4'h3, 16'hA5C3, 1'b1);
      chk("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      chk("t1_cs_before_pop", 32'(cs_n), 32'h3);
      @(negedge clk);
      chk("t1_cs_sel0", 32'(cs_n), 32'h2);
      wait_idle(1'b0, 400);
      chk("t1_done_once", n_done, 1);
      chk("t1_cs_idle", 32'(cs_n), 32'h3);

      // 2: level held high sends once; a fresh edge sends again
      @(posedge clk); #1;
      cmd_sel = 1'b1; cmd_addr = 4'h5; cmd_data = 16'h1234; cmd_valid = 1'b1;
      exp_q.push_back(21'h151234); n_sent++;
      repeat (500) @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(posedge clk); #1 cmd_valid = 1'b1;
      exp_q.push_back(21'h151234); n_sent++;
      @(posedge clk); #1 cmd_valid = 1'b0;
      wait_idle(1'b0, 600);
      chk("t2_done_count", n_done, 3);

      // 3: overflow while shifting; clear racing a drop keeps the flag
      send(1'b0, 4'h1, 16'h1111, 1'b1);
      repeat (30) @(posedge clk);
      chk("t3_shifting", 32'(cs_n), 32'h2);
      send(1'b1, 4'h2, 16'h2222, 1'b1);
      send(1'b0, 4'h3, 16'h3333, 1'b1);
      send(1'b1, 4'h4, 16'h4444, 1'b1);
      chk("t3_not_full", 32'(fifo_full), 32'd0);
      send(1'b0, 4'h5, 16'h5555, 1'b1);
      chk("t3_full", 32'(fifo_full), 32'd1);
      chk("t3_no_ovf_yet", 32'(overflow), 32'd0);
      send(1'b1, 4'h6, 16'h6666, 1'b0);
      chk("t3_ovf_set", 32'(overflow), 32'd1);
      @(posedge clk); #1;
      cmd_sel = 1'b0; cmd_addr = 4'h7; cmd_data = 16'h7777; cmd_valid = 1'b1; ovf_clr = 1'b1;
      @(posedge clk); #1 cmd_valid = 1'b0; ovf_clr = 1'b0;
      chk("t3_ovf_clr_vs_drop", 32'(overflow), 32'd1);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      chk("t3_ovf_cleared", 32'(overflow), 32'd0);
      wait_idle(1'b0, 1500);
      chk("t3_done_count", n_done, n_sent);

      // 4: alternating selects
      send(1'b1, 4'hA, 16'hBEEF, 1'b1);
      send(1'b0, 4'hB, 16'h0F0F, 1'b1);
      send(1'b1, 4'hC, 16'hF00D, 1'b1);
      send(1'b0, 4'hD, 16'h8001, 1'b1);
      wait_idle(1'b0, 1200);
      chk("t4_done_count", n_done, n_sent);

      // 5: reset during bit 10 aborts the frame
      send(1'b1, 4'h9, 16'hC0DE, 1'b1);
      repeat (2 + CD + 10 * 2 * CD + 3) @(posedge clk);
      done_before = n_done;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_cs_abort", 32'(cs_n), 32'h3);
      chk("t5_sclk_abort", 32'(sclk), 32'd0);
      chk("t5_busy_abort", 32'(busy), 32'd0);
      exp_q.delete(); n_sent--;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t5_no_done", n_done, done_before);
      chk("t5_fifo_empty", 32'(busy), 32'd0);
      chk("t5_cs_idle", 32'(cs_n), 32'h3);

      // 6: push coinciding with the IDLE pop while full, CLK_DIV=2
      send2(1'b0, 4'h1, 16'hAAAA);
      send2(1'b1, 4'h2, 16'hBBBB);
      send2(1'b0, 4'h3, 16'hCCCC);
      chk("t6_full", 32'(fifo_full2), 32'd1);
      begin
         int n = 0;
         while (n < 300 && !done2) begin @(negedge clk); n++; end
         chk("t6_done_timeout", 32'(n < 300), 32'd1);
      end
      repeat (CD2) @(posedge clk);
      #1;
      cmd_sel2 = 1'b1; cmd_addr2 = 4'h4; cmd_data2 = 16'hDDDD; cmd_valid2 = 1'b1;
      exp2_q.push_back(21'h14DDDD); n_sent2++;
      @(posedge clk); #1 cmd_valid2 = 1'b0;
      chk("t6_no_ovf", 32'(overflow2), 32'd0);
      chk("t6_still_full", 32'(fifo_full2), 32'd1);
      wait_idle(1'b1, 800);
      chk("t6_done_count", n_done2, 4);

      chk("sb_empty", exp_q.size(), 0);
      chk("sb2_empty", exp2_q.size(), 0);
      chk("done_total", n_done, n_sent);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
